mem_port_sequencer: RTL and testbench
=====================================

// Module: mem_port_sequencer
// PURPOSE
//  Arbitrates and sequences the single byte-wide, byte-addressed (big-endian) unified memory for two requesters.
//  - Requesters: instruction fetch (IF, word reads) and data access (D, LB/LBU/LW/SB/SW).
//  - Splits each word access into 4 single-byte beats; assembles or scatters bytes; extends bytes per d_unsigned.
//  - Sits between ProgramCounter/control and the memory array.
// PARAMETERS
//  AW     9   memory byte-address width (512 bytes); request addresses truncated to AW bits
// PORTS
//  Clk        in   1   clock, rising edge
//  reset      in   1   synchronous, active-high
//  if_req     in   1   fetch request; held with if_addr until if_ready
//  if_addr    in   32  fetch byte address (PC)
//  if_ready   out  1   one-cycle pulse: if_data valid (or if_err)
//  if_data    out  32  fetched instruction, {M[a],M[a+1],M[a+2],M[a+3]}
//  if_err     out  1   with if_ready: misaligned fetch
//  d_req      in   1   data request; held with d_* until d_ready
//  d_we       in   1   1=store, 0=load
//  d_size     in   1   0=byte, 1=word
//  d_unsigned in   1   byte load: 1=zero-extend, 0=sign-extend
//  d_addr     in   32  data byte address
//  d_wdata    in   32  store data (SB uses [7:0])
//  d_ready    out  1   one-cycle pulse: access complete
//  d_rdata    out  32  load result, valid with d_ready on loads
//  d_err      out  1   with d_ready: misaligned word access
//  mem_en     out  1   byte access this cycle
//  mem_we     out  1   byte write this cycle
//  mem_addr   out  AW  byte address
//  mem_wdata  out  8   write byte
//  mem_rdata  in   8   read byte, combinational from mem_addr
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; beat=0; last_grant=D (so the first tie goes to IF).
//  - Reset: all outputs 0, including if_data, d_rdata and all mem_*.
//  - States:
//    - IDLE:  sample requests; on a grant, latch addr/op/wdata, then go to XFER, or to DONE if misaligned.
//    - XFER:  one byte beat per cycle, beat = 0..N-1 (N=4 word, N=1 byte). Last beat -> DONE.
//    - DONE:  pulse the winner's ready (+err); requests ignored this cycle -> IDLE.
//  - Arbitration, evaluated in IDLE only:
//    - Single requester wins.
//    - Both requesting: grant the side not granted last (round-robin). last_grant updates on grant.
//  - Latency (request first seen in IDLE at cycle T):
//    - byte access: ready at T+2.
//    - word access: ready at T+5.
//    - misaligned word (addr[1:0]!=0): ready+err at T+1, no mem_en, rdata unchanged.
//  - Beat k address = latched addr[AW-1:0] + k. Byte accesses may use any alignment.
//  - mem_en is asserted in XFER only; mem_* are decoded from registered state, not from inputs.
//  - Loads:
//    - mem_rdata is captured at the end of each beat into byte 3-k (word) or byte 0 (byte).
//    - LB result: {{24{b[7]}},b}. LBU result: {24'b0,b}.
//    - IF always performs word reads.
//  - Stores: beat k drives wdata[31-8k -: 8] (SW) or wdata[7:0] (SB), with mem_we=1.
//  - if_data/d_rdata hold their last value until the next completed load on that port.
//  - A requester dropping req mid-transfer does not abort it; the transfer completes and ready still pulses.
//  - Reset mid-XFER:
//    - next cycle IDLE, mem_en=0, no ready pulse.
//    - partial store bytes already written stay written.
// STRUCTURE
//  - Package mips_mem_pkg: state encoding (IDLE/XFER/DONE); SIZE_BYTE/SIZE_WORD; GRANT_IF/GRANT_D; WORD_BEATS=4.
//  - Sub-module mem_byte_lane: beat counter plus byte assembly/scatter and extension.
//  - Top keeps FSM and arbitration.
// TESTING
//  - Fetch: M[0..3]=24 01 00 2C, if_req addr 0 -> if_ready at T+5, if_data=0x2401002C, 4 beats on addr 0..3.
//  - LB/LBU: M[0x21]=0x9C:
//    - LB  -> d_rdata=0xFFFFFF9C.
//    - LBU -> d_rdata=0x0000009C.
//    - both: ready at T+2.
//  - SW 0xDEADBEEF @0x40: bytes DE,AD,BE,EF written to 0x40..0x43 in order.
//    - Then SB 0x11 @0x41: LW @0x40 -> 0xDE11BEEF.
//  - Tie: if_req and d_req held together from reset:
//    - grant order IF, D, IF, D.
//    - neither requester waits more than one transaction.
//  - Misaligned: LW @0x42 -> d_ready & d_err at T+1, no mem_en, d_rdata unchanged.
//  - Reset asserted during beat 2 of SW -> IDLE next cycle, no d_ready, bytes 0..1 written only, busy=0.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the byte-wide unified memory port sequencer.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic {
        SIZE_BYTE = 1'b0,
        SIZE_WORD = 1'b1
    } size_e;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_D  = 1'b1
    } grant_e;

    localparam int unsigned WORD_BEATS = 4;
    localparam int unsigned BEAT_W     = 2;

    function automatic logic [31:0] extend_byte(input logic [7:0] b, input logic is_unsigned);
        return is_unsigned ? {24'b0, b} : {{24{b[7]}}, b};
    endfunction

endpackage

// File: rtl/mem_byte_lane.sv
// Beat counter plus big-endian byte scatter for stores and byte gather/extension for loads.
module mem_byte_lane
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          start_i,
    input  logic          step_i,
    input  size_e         size_i,
    input  logic          uns_i,
    input  logic [AW-1:0] base_addr_i,
    input  logic [31:0]   wdata_i,
    input  logic [7:0]    rdata_i,
    output logic          last_o,
    output logic [AW-1:0] addr_o,
    output logic [7:0]    wdata_o,
    output logic [31:0]   result_o
);

    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [23:0]       asm_q, asm_d;
    logic [BEAT_W-1:0] lane_sel;

    // Beat k of a word carries byte 3-k (most significant byte first).
    assign lane_sel = BEAT_W'(WORD_BEATS - 1) - beat_q;
    assign last_o   = (size_i == SIZE_WORD) ? (beat_q == BEAT_W'(WORD_BEATS - 1)) : 1'b1;
    assign addr_o   = base_addr_i + AW'(beat_q);
    assign wdata_o  = (size_i == SIZE_WORD) ? wdata_i[{lane_sel, 3'b000} +: 8] : wdata_i[7:0];

    // The final beat's byte is taken straight from the memory so the result is ready at the last edge.
    assign result_o = (size_i == SIZE_WORD) ? {asm_q, rdata_i} : extend_byte(rdata_i, uns_i);

    always_comb begin
        beat_d = beat_q;
        asm_d  = asm_q;
        if (start_i) begin
            beat_d = '0;
        end else if (step_i) begin
            beat_d = last_o ? '0 : beat_q + 1'b1;
            if (size_i == SIZE_WORD) begin
                asm_d = {asm_q[15:0], rdata_i};
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            beat_q <= '0;
            asm_q  <= '0;
        end else begin
            beat_q <= beat_d;
            asm_q  <= asm_d;
        end
    end

endmodule

// File: rtl/mem_port_sequencer.sv
// Round-robin arbiter and sequencer sharing one byte-wide memory between instruction fetch and data access.
module mem_port_sequencer
    import mips_mem_pkg::*;
#(
    parameter int unsigned AW = 9
) (
    input  logic          Clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [31:0]   if_addr,
    output logic          if_ready,
    output logic [31:0]   if_data,
    output logic          if_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic          d_size,
    input  logic          d_unsigned,
    input  logic [31:0]   d_addr,
    input  logic [31:0]   d_wdata,
    output logic          d_ready,
    output logic [31:0]   d_rdata,
    output logic          d_err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          busy
);

    state_e        state_q, state_d;
    grant_e        grant_q, grant_d;
    grant_e        last_grant_q, last_grant_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          we_q, we_d;
    size_e         size_q, size_d;
    logic          uns_q, uns_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [31:0]   if_data_q, if_data_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          take;
    grant_e        sel;
    logic          misaligned;
    logic          lane_last;
    logic [AW-1:0] lane_addr;
    logic [7:0]    lane_wdata;
    logic [31:0]   lane_result;

    logic          unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:AW], d_addr[31:AW]};

    mem_byte_lane #(.AW(AW)) u_lane (
        .Clk         (Clk),
        .reset       (reset),
        .start_i     (take),
        .step_i      (state_q == ST_XFER),
        .size_i      (size_q),
        .uns_i       (uns_q),
        .base_addr_i (addr_q),
        .wdata_i     (wdata_q),
        .rdata_i     (mem_rdata),
        .last_o      (lane_last),
        .addr_o      (lane_addr),
        .wdata_o     (lane_wdata),
        .result_o    (lane_result)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        we_d         = we_q;
        size_d       = size_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        if_data_d    = if_data_q;
        d_rdata_d    = d_rdata_q;
        take         = 1'b0;
        sel          = GRANT_IF;
        misaligned   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req && d_req) begin
                    sel = (last_grant_q == GRANT_D) ? GRANT_IF : GRANT_D;
                end else if (d_req) begin
                    sel = GRANT_D;
                end
                take = if_req || d_req;
                if (take) begin
                    grant_d      = sel;
                    last_grant_d = sel;
                    if (sel == GRANT_IF) begin
                        addr_d     = if_addr[AW-1:0];
                        we_d       = 1'b0;
                        size_d     = SIZE_WORD;
                        uns_d      = 1'b0;
                        wdata_d    = '0;
                        misaligned = (if_addr[1:0] != 2'b00);
                    end else begin
                        addr_d     = d_addr[AW-1:0];
                        we_d       = d_we;
                        size_d     = d_size ? SIZE_WORD : SIZE_BYTE;
                        uns_d      = d_unsigned;
                        wdata_d    = d_wdata;
                        misaligned = d_size && (d_addr[1:0] != 2'b00);
                    end
                    err_d   = misaligned;
                    state_d = misaligned ? ST_DONE : ST_XFER;
                end
            end
            ST_XFER: begin
                if (lane_last) begin
                    state_d = ST_DONE;
                    if (!we_q) begin
                        if (grant_q == GRANT_IF) begin
                            if_data_d = lane_result;
                        end else begin
                            d_rdata_d = lane_result;
                        end
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= GRANT_IF;
            last_grant_q <= GRANT_D;
            addr_q       <= '0;
            we_q         <= 1'b0;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            if_data_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            if_data_q    <= if_data_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // Reset suppresses the in-flight beat so an aborted store never commits the byte of that cycle.
    assign mem_en    = (state_q == ST_XFER) && !reset;
    assign mem_we    = mem_en && we_q;
    assign mem_addr  = mem_en ? lane_addr : '0;
    assign mem_wdata = mem_we ? lane_wdata : '0;

    assign busy      = (state_q != ST_IDLE);
    assign if_ready  = (state_q == ST_DONE) && (grant_q == GRANT_IF);
    assign d_ready   = (state_q == ST_DONE) && (grant_q == GRANT_D);
    assign if_err    = if_ready && err_q;
    assign d_err     = d_ready && err_q;
    assign if_data   = if_data_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Self-checking bench: byte-array memory, transaction-level reference model, directed and random accesses.
module tb_mem_port_sequencer;

    logic        Clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_data;
    logic        if_err;
    logic        d_req;
    logic        d_we;
    logic        d_size;
    logic        d_unsigned;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic [31:0] d_rdata;
    logic        d_err;
    logic        mem_en;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        busy;

    logic [7:0]  mem     [0:511];
    logic [7:0]  ref_mem [0:511];
    logic [31:0] exp_if;
    logic [31:0] exp_d;
    int          n_checks;
    int          n_fail;

    mem_port_sequencer #(.AW(9)) dut (
        .Clk        (Clk),
        .reset      (reset),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_ready   (if_ready),
        .if_data    (if_data),
        .if_err     (if_err),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_size     (d_size),
        .d_unsigned (d_unsigned),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ready    (d_ready),
        .d_rdata    (d_rdata),
        .d_err      (d_err),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .busy       (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge Clk) if (mem_we) mem[mem_addr] = mem_wdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One transaction from a single requester; caller is at a negedge with the DUT idle.
    task automatic xact(input bit is_if, input bit we, input bit word, input bit uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
        logic [8:0]  base;
        logic [8:0]  idx;
        logic [31:0] exp_data;
        logic [7:0]  exp_byte;
        bit          mis;
        bit          got_rdy;
        bit          got_err;
        bit          busy1;
        int unsigned n_exp, lat_exp, lat, xrdy;
        logic [8:0]  q_addr[$];
        logic        q_we[$];
        logic [7:0]  q_wd[$];
        if (is_if) begin
            we = 1'b0; word = 1'b1; uns = 1'b0;
        end
        base    = addr[8:0];
        mis     = word && (addr[1:0] != 2'b00);
        n_exp   = mis ? 0 : (word ? 4 : 1);
        lat_exp = mis ? 1 : (word ? 5 : 2);
        if (word)
            exp_data = {ref_mem[base], ref_mem[base + 9'd1], ref_mem[base + 9'd2], ref_mem[base + 9'd3]};
        else
            exp_data = uns ? {24'h0, ref_mem[base]} : {{24{ref_mem[base][7]}}, ref_mem[base]};

        if (is_if) begin
            if_req = 1'b1; if_addr = addr;
        end else begin
            d_req = 1'b1; d_we = we; d_size = word; d_unsigned = uns; d_addr = addr; d_wdata = wdata;
        end
        lat = 0; xrdy = 0; got_rdy = 0; got_err = 0; busy1 = 0;
        while (!got_rdy && lat < 20) begin
            @(negedge Clk);
            lat++;
            if (lat == 1) busy1 = busy;
            if (mem_en) begin
                q_addr.push_back(mem_addr);
                q_we.push_back(mem_we);
                q_wd.push_back(mem_wdata);
            end
            if (is_if ? if_ready : d_ready) begin
                got_rdy = 1;
                got_err = is_if ? if_err : d_err;
            end
            if (is_if ? d_ready : if_ready) xrdy++;
        end
        if_req = 1'b0;
        d_req  = 1'b0;

        if (!we && !mis) begin
            if (is_if) exp_if = exp_data;
            else       exp_d  = exp_data;
        end
        chk("latency", lat, lat_exp);
        chk("err", {31'b0, got_err}, {31'b0, mis});
        chk("busy", {31'b0, busy1}, 32'd1);
        chk("other_ready", xrdy, 0);
        chk("if_data", if_data, exp_if);
        chk("d_rdata", d_rdata, exp_d);
        chk("beats", q_addr.size(), n_exp);
        for (int unsigned k = 0; k < n_exp && k < q_addr.size(); k++) begin
            idx      = base + 9'(k);
            exp_byte = word ? 8'((wdata >> (8 * (3 - k))) & 32'hFF) : wdata[7:0];
            chk("beat_addr", {23'b0, q_addr[k]}, {23'b0, idx});
            chk("beat_we", {31'b0, q_we[k]}, {31'b0, we});
            if (we) chk("beat_wdata", {24'b0, q_wd[k]}, {24'b0, exp_byte});
            if (we) ref_mem[idx] = exp_byte;
        end
        @(negedge Clk);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        reset = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        reset = 1'b0;
        exp_if = '0;
        exp_d  = '0;
    endtask

    initial begin
        logic [7:0]  b;
        logic [31:0] a;
        int unsigned kind;
        int unsigned mism;
        int unsigned order[$];
        bit          saw_ready;

        n_checks = 0; n_fail = 0;
        reset = 1'b1;
        if_req = 0; if_addr = '0;
        d_req = 0; d_we = 0; d_size = 0; d_unsigned = 0; d_addr = '0; d_wdata = '0;
        exp_if = '0; exp_d = '0;
        for (int i = 0; i < 512; i++) begin
            b = 8'($urandom);
            mem[i] = b; ref_mem[i] = b;
        end
        mem[0] = 8'h24; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h2C; mem[9'h21] = 8'h9C;
        ref_mem[0] = 8'h24; ref_mem[1] = 8'h01; ref_mem[2] = 8'h00; ref_mem[3] = 8'h2C; ref_mem[9'h21] = 8'h9C;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_mem", {21'b0, mem_en, mem_we, mem_addr, mem_wdata}, 0);
        reset = 1'b0;
        @(negedge Clk);
        chk("rst_if", {if_ready, if_err, if_data[29:0]}, 0);
        chk("rst_ifdata", if_data, 0);
        chk("rst_d", {d_ready, d_err, 30'b0}, 0);
        chk("rst_drdata", d_rdata, 0);
        chk("idle_mem_en", {31'b0, mem_en}, 0);

        // Directed
        xact(1, 0, 1, 0, 32'h0000_0000, 0);
        chk("fetch0", if_data, 32'h2401002C);
        xact(0, 0, 0, 0, 32'h0000_0021, 0);
        chk("lb", d_rdata, 32'hFFFFFF9C);
        xact(0, 0, 0, 1, 32'h0000_0021, 0);
        chk("lbu", d_rdata, 32'h0000009C);
        xact(0, 1, 1, 0, 32'h0000_0040, 32'hDEADBEEF);
        chk("sw_mem", {mem[9'h40], mem[9'h41], mem[9'h42], mem[9'h43]}, 32'hDEADBEEF);
        xact(0, 1, 0, 0, 32'h0000_0041, 32'hABCDEF11);
        xact(0, 0, 1, 0, 32'h0000_0040, 0);
        chk("lw_merge", d_rdata, 32'hDE11BEEF);
        xact(0, 0, 1, 0, 32'h0000_0042, 0);
        chk("misaligned_hold", d_rdata, 32'hDE11BEEF);

        // Both requesters held from reset: strict alternation starting with IF
        @(negedge Clk);
        reset = 1'b1;
        if_req = 1; if_addr = 32'h0;
        d_req = 1; d_we = 0; d_size = 0; d_unsigned = 1; d_addr = 32'h21;
        @(negedge Clk);
        reset = 1'b0;
        for (int c = 0; c < 60 && order.size() < 4; c++) begin
            @(negedge Clk);
            if (if_ready) begin
                order.push_back(0);
                chk("tie_ifdata", if_data, 32'h2401002C);
            end
            if (d_ready) begin
                order.push_back(1);
                chk("tie_drdata", d_rdata, 32'h0000009C);
            end
        end
        if_req = 0; d_req = 0;
        exp_if = 32'h2401002C; exp_d = 32'h0000009C;
        chk("tie_count", order.size(), 4);
        for (int unsigned k = 0; k < 4; k++)
            chk("tie_order", (k < order.size()) ? order[k] : 32'hFFFF_FFFF, k % 2);
        @(negedge Clk);

        // Reset during beat 2 of a word store
        d_req = 1; d_we = 1; d_size = 1; d_unsigned = 0; d_addr = 32'h7700_0080; d_wdata = 32'hA1B2C3D4;
        saw_ready = 0;
        repeat (3) begin
            @(negedge Clk);
            if (d_ready) saw_ready = 1;
        end
        chk("rst_mid_beat2", {22'b0, mem_en, mem_addr}, {22'b0, 1'b1, 9'h082});
        reset = 1'b1;
        d_req = 0;
        @(negedge Clk);
        chk("rst_mid_busy", {31'b0, busy}, 0);
        chk("rst_mid_memen", {31'b0, mem_en}, 0);
        if (d_ready) saw_ready = 1;
        reset = 1'b0;
        @(negedge Clk);
        if (d_ready) saw_ready = 1;
        chk("rst_mid_noready", {31'b0, saw_ready}, 0);
        chk("rst_mid_bytes", {mem[9'h80], mem[9'h81], mem[9'h82], mem[9'h83]},
            {8'hA1, 8'hB2, ref_mem[9'h82], ref_mem[9'h83]});
        ref_mem[9'h80] = 8'hA1; ref_mem[9'h81] = 8'hB2;
        exp_if = '0; exp_d = '0;

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 4);
            a = $urandom;
            if ((kind == 0 || kind >= 3) && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            case (kind)
                0: xact(1, 0, 1, 0, a, 0);
                1: xact(0, 0, 0, 1'($urandom), a, 0);
                2: xact(0, 1, 0, 0, a, $urandom);
                3: xact(0, 0, 1, 0, a, 0);
                default: xact(0, 1, 1, 0, a, $urandom);
            endcase
        end

        mism = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) mism++;
        chk("mem_image", mism, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
